// File: rtl/flag_pkg.sv
// Shared flag indices, flag-vector width and branch-condition encodings for flag_unit.
// FLAG_PARITY_EN widens the flag vector to include the parity flag.
package flag_pkg;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;
  localparam int FLAG_P = 4;

`ifdef FLAG_PARITY_EN
  localparam int FLAG_W = 5;
`else
  localparam int FLAG_W = 4;
`endif

  localparam logic [2:0] COND_ALW = 3'd0;
  localparam logic [2:0] COND_Z   = 3'd1;
  localparam logic [2:0] COND_NZ  = 3'd2;
  localparam logic [2:0] COND_S   = 3'd3;
  localparam logic [2:0] COND_NS  = 3'd4;
  localparam logic [2:0] COND_C   = 3'd5;
  localparam logic [2:0] COND_NC  = 3'd6;
  localparam logic [2:0] COND_V   = 3'd7;

  function automatic logic cond_eval(input logic [2:0] sel, input logic s, input logic z,
                                     input logic c, input logic v);
    logic r;
    r = 1'b1;
    case (sel)
      COND_ALW: r = 1'b1;
      COND_Z:   r = z;
      COND_NZ:  r = ~z;
      COND_S:   r = s;
      COND_NS:  r = ~s;
      COND_C:   r = c;
      COND_NC:  r = ~c;
      COND_V:   r = v;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// DEPTH-entry LIFO of flag vectors; push writes at the edge, pop data is the combinational top entry.
// Overflowing push / underflowing pop is dropped and reported as a one-cycle err pulse.
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_dat,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty,
  output logic         err,
  output logic         pop_ok
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [IDX_W-1:0] top;
  logic             push_ok;
  logic [W-1:0]     mem [DEPTH];

  // Simultaneous push and pop cancel out: nothing moves and nothing is flagged.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err     = (push & ~pop & full) | (pop & ~push & empty);

  assign top    = count[IDX_W-1:0] - IDX_W'(1);
  assign rd_dat = mem[top];

  always_comb begin
    count_nxt = count;
    if (push_ok)
      count_nxt = count + CNT_W'(1);
    else if (pop_ok)
      count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[count[IDX_W-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/flag_unit.sv
// Status-flag register with masked update, CALL/RET flag stack and branch-condition evaluator.
// Flags and stack status update 1 cycle after sampling; take is combinational. FLAG_PARITY_EN adds P.
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             upd,
  input  logic [4:0]       upd_mask,
  input  logic             push,
  input  logic             pop,
  input  logic [2:0]       cond_sel,
  output logic             S_f,
  output logic             Z_f,
  output logic             C_f,
  output logic             V_f,
  output logic             P_f,
  output logic             take,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  logic [FLAG_W-1:0] flg;
  logic [FLAG_W-1:0] calc;
  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] stk_rd;
  logic              stk_perr;
  logic              pop_ok;

  always_comb begin
    calc         = '0;
    calc[FLAG_S] = alu_res[WIDTH-1];
    calc[FLAG_Z] = (alu_res == '0);
    calc[FLAG_C] = alu_carry;
    calc[FLAG_V] = alu_ovf;
`ifdef FLAG_PARITY_EN
    calc[FLAG_P] = ~^alu_res;
`endif
  end

  assign mask = upd_mask[FLAG_W-1:0];

  // Push stores the pre-update flags; a completed pop overrides any same-cycle update.
  flag_stack #(
    .DEPTH (DEPTH),
    .W     (FLAG_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_dat (flg),
    .rd_dat (stk_rd),
    .full   (stk_full),
    .empty  (stk_empty),
    .err    (stk_perr),
    .pop_ok (pop_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flg <= '0;
    else if (pop_ok)
      flg <= stk_rd;
    else if (upd)
      flg <= (flg & ~mask) | (calc & mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stk_err <= 1'b0;
    else if (stk_perr)
      stk_err <= 1'b1;
  end

  assign S_f = flg[FLAG_S];
  assign Z_f = flg[FLAG_Z];
  assign C_f = flg[FLAG_C];
  assign V_f = flg[FLAG_V];

`ifdef FLAG_PARITY_EN
  assign P_f = flg[FLAG_P];
`else
  logic unused_mask;
  assign P_f         = 1'b0;
  assign unused_mask = upd_mask[4];
`endif

  assign take = cond_eval(cond_sel, S_f, Z_f, C_f, V_f);

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: directed steps queue expected outputs, a monitor checks them.
module tb_flag_unit;

`ifdef FLAG_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_res;
  logic       alu_carry, alu_ovf, upd, push, pop;
  logic [4:0] upd_mask;
  logic [2:0] cond_sel;
  logic       S_f, Z_f, C_f, V_f, P_f, take, stk_full, stk_empty, stk_err;

  flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_res   (alu_res),
    .alu_carry (alu_carry),
    .alu_ovf   (alu_ovf),
    .upd       (upd),
    .upd_mask  (upd_mask),
    .push      (push),
    .pop       (pop),
    .cond_sel  (cond_sel),
    .S_f       (S_f),
    .Z_f       (Z_f),
    .C_f       (C_f),
    .V_f       (V_f),
    .P_f       (P_f),
    .take      (take),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  event       mon_ev;
  logic [8:0] m_exp, m_obs;
  string      m_name;

  function automatic logic [8:0] ev(input logic s, input logic z, input logic c, input logic v,
                                    input logic p, input logic tk, input logic f, input logic e,
                                    input logic er);
    return {s, z, c, v, p, tk, f, e, er};
  endfunction

  // Monitor: compares whatever is pending at each falling edge, or on demand for async checks.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() != 0) begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        m_obs  = {S_f, Z_f, C_f, V_f, P_f, take, stk_full, stk_empty, stk_err};
        n_tests++;
        if (m_obs !== m_exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b (S Z C V P take full empty err)",
                   m_name, m_obs, m_exp);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [7:0] res, input logic cy, input logic ov,
                      input logic u, input logic [4:0] m, input logic ps, input logic pp,
                      input logic [2:0] cs, input logic [8:0] e);
    @(negedge clk);
    #1;
    alu_res   = res;
    alu_carry = cy;
    alu_ovf   = ov;
    upd       = u;
    upd_mask  = m;
    push      = ps;
    pop       = pp;
    cond_sel  = cs;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; alu_res = '0; alu_carry = 0; alu_ovf = 0; upd = 0; upd_mask = '0;
    push = 0; pop = 0; cond_sel = 3'd0;
    #2;
    exp_q.push_back(ev(0,0,0,0,0, 1, 0,1,0)); name_q.push_back("reset_state");
    -> mon_ev;
    #1 rst = 1'b0;

    //   name            res    cy ov u  mask   ps pp cs   S Z C V P   tk F E Er
    step("upd_all_zero", 8'h00, 0, 0, 1, 5'h1F, 0, 0, 1, ev(0,1,0,0,PAR, 1, 0,1,0));
    step("upd_s_only",   8'h80, 0, 0, 1, 5'h08, 0, 0, 3, ev(1,1,0,0,PAR, 1, 0,1,0));
    step("cond_ns",      8'h00, 0, 0, 0, 5'h00, 0, 0, 4, ev(1,1,0,0,PAR, 0, 0,1,0));
    step("cond_nz",      8'h00, 0, 0, 0, 5'h00, 0, 0, 2, ev(1,1,0,0,PAR, 0, 0,1,0));
    step("set_cv",       8'h01, 1, 1, 1, 5'h1F, 0, 0, 5, ev(0,0,1,1,0,   1, 0,1,0));
    step("push_cv",      8'h00, 0, 0, 0, 5'h00, 1, 0, 7, ev(0,0,1,1,0,   1, 0,0,0));
    step("clear_flags",  8'h03, 0, 0, 1, 5'h0F, 0, 0, 6, ev(0,0,0,0,0,   1, 0,0,0));
    step("pop_restore",  8'h00, 0, 0, 0, 5'h00, 0, 1, 5, ev(0,0,1,1,0,   1, 0,1,0));
    step("push_upd",     8'h00, 0, 0, 1, 5'h1F, 1, 0, 1, ev(0,1,0,0,PAR, 1, 0,0,0));
    step("pop_upd",      8'h80, 1, 0, 1, 5'h1F, 0, 1, 3, ev(0,0,1,1,0,   0, 0,1,0));
    step("push_pop",     8'h80, 0, 0, 1, 5'h1F, 1, 1, 4, ev(1,0,0,0,0,   0, 0,1,0));

    step("fill_1",       8'h00, 0, 0, 1, 5'h1F, 1, 0, 0, ev(0,1,0,0,PAR, 1, 0,0,0));
    step("fill_2",       8'h01, 1, 0, 1, 5'h1F, 1, 0, 0, ev(0,0,1,0,0,   1, 0,0,0));
    step("fill_3",       8'hFF, 0, 1, 1, 5'h1F, 1, 0, 0, ev(1,0,0,1,PAR, 1, 0,0,0));
    step("fill_4_full",  8'h00, 0, 0, 0, 5'h00, 1, 0, 0, ev(1,0,0,1,PAR, 1, 1,0,0));
    step("push_overflow",8'h00, 0, 0, 1, 5'h04, 1, 0, 0, ev(1,1,0,1,PAR, 1, 1,0,1));
    step("drain_1",      8'h00, 0, 0, 0, 5'h00, 0, 1, 7, ev(1,0,0,1,PAR, 1, 0,0,1));
    step("drain_2",      8'h00, 0, 0, 0, 5'h00, 0, 1, 7, ev(0,0,1,0,0,   0, 0,0,1));
    step("drain_3",      8'h00, 0, 0, 0, 5'h00, 0, 1, 7, ev(0,1,0,0,PAR, 0, 0,0,1));
    step("drain_4_empty",8'h00, 0, 0, 0, 5'h00, 0, 1, 7, ev(1,0,0,0,0,   0, 0,1,1));
    step("pop_underflow",8'h01, 1, 0, 1, 5'h02, 0, 1, 5, ev(1,0,1,0,0,   1, 0,1,1));
    step("push_pre_rst", 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, ev(1,0,1,0,0,   1, 0,0,1));

    // Reset asserted between edges must clear state without waiting for a clock.
    @(negedge clk);
    #1;
    rst = 1'b1; push = 0; cond_sel = 3'd0;
    #1;
    exp_q.push_back(ev(0,0,0,0,0, 1, 0,1,0)); name_q.push_back("async_rst");
    -> mon_ev;
    #1 rst = 1'b0;

    step("post_rst",     8'h00, 0, 0, 0, 5'h00, 0, 0, 1, ev(0,0,0,0,0,   0, 0,1,0));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised status-flag unit for the SAP-II datapath, replacing the single-register sign/zero flag with a WIDTH-generic flag register (sign, zero, carry, overflow, optional parity). Flags update under per-flag mask control from the ALU result and can be saved and restored on CALL/RET through a DEPTH-entry flag stack. A condition evaluator drives the branch-taken signal for conditional jumps to the controller.

## Interface
- WIDTH, 8, ALU result width (≥2)
- DEPTH, 4, flag-stack entries (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- alu_res  in  WIDTH  ALU result
- alu_carry  in  1  ALU carry/borrow out
- alu_ovf  in  1  ALU signed overflow
- upd  in  1  flag update strobe
- upd_mask  in  5  per-flag enable: [4]P [3]S [2]Z [1]C [0]V
- push  in  1  save current flags to stack
- pop  in  1  restore flags from stack
- cond_sel  in  3  branch condition select
- S_f, Z_f, C_f, V_f, P_f  out  1 each  registered flags
- take  out  1  condition result
- stk_full  out  1  stack holds DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky push-full / pop-empty error

## Operation
- Flag computation: S = alu_res[WIDTH-1]; Z = (alu_res == 0); C = alu_carry; V = alu_ovf; P = 1 when alu_res has even count of ones.
- upd=1: each flag with its mask bit set loads its computed value at the clock edge; unmasked flags hold. upd=0: mask ignored.
- push=1, pop=0, not full: current (pre-update) flag vector written at top, count+1. upd in same cycle still applies to flag register.
- pop=1, push=0, not empty: flag register loads top entry, count-1; upd in same cycle ignored (pop has priority).
- push=1 and pop=1: stack and count unchanged, no error; upd applies normally.
- push when full or pop when empty: operation dropped, stk_err set; upd applies normally.
- stk_err cleared only by rst.
- cond_sel: 0 always(1), 1 Z, 2 !Z, 3 S, 4 !S, 5 C, 6 !C, 7 V.
- take combinational from registered flags and cond_sel; no dependency on alu_res.

## Timing
- rst asserted: all flags 0, count 0, stk_empty=1, stk_full=0, stk_err=0, take = (cond_sel==0); stack contents undefined and never read before a push.
- Flag update latency: 1 cycle (inputs sampled at edge N, flags valid after edge N).
- Pop restore latency: 1 cycle.
- stk_full/stk_empty/stk_err registered, valid after the edge that changes count.
- Back-to-back push/pop on consecutive cycles fully supported; DEPTH pushes reach full, DEPTH pops return empty.
- rst mid-sequence: count and flags cleared immediately, independent of clk.

## Configuration
- FLAG_PARITY_EN defined: P_f computed, stored on stack, restored on pop, masked by upd_mask[4].
- Undefined: P_f tied 0, upd_mask[4] ignored, stack entries 4 bits wide; all other behaviour identical.

## Structure
- Package flag_pkg: flag index constants (FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_S=3, FLAG_P=4), flag vector width constant (4 or 5 per FLAG_PARITY_EN), cond_sel encoding constants COND_ALW…COND_V.
- One sub-module: flag_stack — DEPTH-entry LIFO with count, full/empty, push/pop, error pulse; flag_unit owns the sticky error and the flag register.

## Test plan
- rst, then upd=1 mask=5'h1F alu_res=8'h00 -> Z_f=1, S_f=0, P_f=1 after one edge; cond_sel=1 -> take=1.
- upd=1 mask=5'h08 alu_res=8'h80 -> S_f=1, Z_f holds previous 1; cond_sel=3 -> take=1, cond_sel=4 -> take=0.
- Set C_f=1 V_f=1, push, then upd clears all flags, pop -> C_f=1, V_f=1 restored, stk_empty=1.
- DEPTH=4: five pushes -> stk_full=1 after fourth, stk_err=1 after fifth, count stays 4; four pops then stk_empty=1.
- pop with upd=1 same cycle -> flags equal stacked value, ALU values ignored; push+pop same cycle -> count unchanged, stk_err=0.
- Assert rst mid-push sequence between clock edges -> flags 0, stk_empty=1 immediately; build without FLAG_PARITY_EN -> P_f=0 for alu_res=8'h00.
